dev_bus_arbiter: RTL

Shares the single device bus (address, write enable, write data, read result) between two masters: the CPU M-stage bridge port and a DMA master. It sits between those masters and the device-side bridge. Each access is held until the addressed device signals ready, or until a watchdog timeout expires. The arbiter returns a completion pulse, read data and an error flag to the master that owned the access.

---
 rtl/dev_bus_arbiter_if.sv | 47 ++++
 rtl/dev_bus_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dev_bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the device bridge.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface dev_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_done;

  logic        bus_err;

  logic [31:0] dev_addr;
  logic        dev_write_enable;
  logic [31:0] dev_write_data;
  logic        dev_valid;
  logic [31:0] dev_read_result;
  logic        dev_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output bus_err,
    output dev_addr, dev_write_enable, dev_write_data, dev_valid,
    input  dev_read_result, dev_ready
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  bus_err,
    input  dev_addr, dev_write_enable, dev_write_data, dev_valid,
    output dev_read_result, dev_ready
  );
endinterface

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing one device bus between the CPU bridge port and a DMA master,
// with a watchdog that force-completes an access with an error if the device never answers.
module dev_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dev_bus_arbiter_if.slave  bus_if
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          last_dma_q, last_dma_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;
  logic          cpu_done_q, cpu_done_d;
  logic          dma_done_q, dma_done_d;
  logic          err_q, err_d;

  logic          cpu_req_m, dma_req_m;
  logic          grant_cpu;
  logic          busy;
  logic          timed_out;
  logic [31:0]   rd_val;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      err_q       <= err_d;
    end
  end

  // A request still high during its own done pulse belongs to the finished access.
  assign cpu_req_m = bus_if.cpu_req & ~cpu_done_q;
  assign dma_req_m = bus_if.dma_req & ~dma_done_q;
  assign grant_cpu = cpu_req_m & (~dma_req_m | last_dma_q);
  assign busy      = (state_q != IDLE);
  assign timed_out = ~bus_if.dev_ready & (cnt_q == LAST_CNT);
  assign rd_val    = bus_if.dev_ready ? bus_if.dev_read_result : 32'h0;

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          we_d       = bus_if.cpu_we;
          addr_d     = bus_if.cpu_addr;
          wdata_d    = bus_if.cpu_wdata;
          cnt_d      = '0;
          last_dma_d = 1'b0;
          state_d    = BUSY_CPU;
        end else if (dma_req_m) begin
          we_d       = bus_if.dma_we;
          addr_d     = bus_if.dma_addr;
          wdata_d    = bus_if.dma_wdata;
          cnt_d      = '0;
          last_dma_d = 1'b1;
          state_d    = BUSY_DMA;
        end
      end

      BUSY_CPU, BUSY_DMA: begin
        if (bus_if.dev_ready || timed_out) begin
          // Reads that time out return zero; writes leave the read register alone.
          if (state_q == BUSY_CPU) begin
            cpu_done_d = 1'b1;
            if (!we_q) cpu_rdata_d = rd_val;
          end else begin
            dma_done_d = 1'b1;
            if (!we_q) dma_rdata_d = rd_val;
          end
          err_d   = ~bus_if.dev_ready;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus_if.dev_valid        = busy;
  assign bus_if.dev_write_enable = busy & we_q;
  assign bus_if.dev_addr         = busy ? addr_q  : 32'h0;
  assign bus_if.dev_write_data   = busy ? wdata_q : 32'h0;

  assign bus_if.cpu_rdata = cpu_rdata_q;
  assign bus_if.dma_rdata = dma_rdata_q;
  assign bus_if.cpu_done  = cpu_done_q;
  assign bus_if.dma_done  = dma_done_q;
  assign bus_if.bus_err   = err_q;
  assign bus_if.cpu_stall = bus_if.cpu_req & ~cpu_done_q;

endmodule
